// File: rtl/lzx_cmp_seq.sv
// Wide unsigned magnitude comparator built from one shared 4-bit 74HC85-style slice,
// stepped LSB nibble first with the registered slice result fed back as cascade input.
module lzx_cmp_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   gt,
    output logic                   eq,
    output logic                   lt,
    output logic                   err,
    output logic [3:0]             cmp_a,
    output logic [3:0]             cmp_b,
    output logic                   cmp_ig,
    output logic                   cmp_ie,
    output logic                   cmp_il,
    input  logic                   cmp_qg,
    input  logic                   cmp_qe,
    input  logic                   cmp_ql
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [4*NIBBLES-1:0]   a_r;
    logic [4*NIBBLES-1:0]   b_r;
    logic [IW-1:0]          idx;
    logic                   cg;
    logic                   ce;
    logic                   cl;
    logic                   err_acc;

    logic [3:0]             a_nib [NIBBLES];
    logic [3:0]             b_nib [NIBBLES];
    logic [2:0]             q;
    logic                   q_bad;
    logic                   last_step;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_r[4*gi +: 4];
            assign b_nib[gi] = b_r[4*gi +: 4];
        end
    endgenerate

    assign q         = {cmp_qg, cmp_qe, cmp_ql};
    // Anything other than exactly one asserted output means the slice misbehaved.
    assign q_bad     = !((q == 3'b100) || (q == 3'b010) || (q == 3'b001));
    assign last_step = (idx == LAST_IDX);

    always_comb begin
        cmp_a  = 4'd0;
        cmp_b  = 4'd0;
        cmp_ig = 1'b0;
        cmp_ie = 1'b1;
        cmp_il = 1'b0;
        if (state == RUN) begin
            cmp_a  = a_nib[idx];
            cmp_b  = b_nib[idx];
            cmp_ig = cg;
            cmp_ie = ce;
            cmp_il = cl;
        end
    end

    // Operand copies need no reset: they are only read in RUN, which always follows a load.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_r <= a;
            b_r <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cg      <= 1'b0;
            ce      <= 1'b1;
            cl      <= 1'b0;
            err_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx     <= '0;
                        cg      <= 1'b0;
                        ce      <= 1'b1;
                        cl      <= 1'b0;
                        err_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    {cg, ce, cl} <= q;
                    err_acc      <= err_acc | q_bad;
                    if (last_step) begin
                        {gt, eq, lt} <= q;
                        err          <= err_acc | q_bad;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        idx          <= '0;
                        state        <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzx_cmp_seq.sv
// Bench for lzx_cmp_seq: behavioural 74HC85 slice on the cmp_* pins, directed and random
// compares checked against plain integer comparison.
module tb_lzx_cmp_seq;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          busy, done, gt, eq, lt, err;
    logic [3:0]    cmp_a, cmp_b;
    logic          cmp_ig, cmp_ie, cmp_il;
    logic          cmp_qg, cmp_qe, cmp_ql;
    logic          fault_now;

    int            n_assert = 0;
    int            n_fail   = 0;

    lzx_cmp_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_ig(cmp_ig), .cmp_ie(cmp_ie), .cmp_il(cmp_il),
        .cmp_qg(cmp_qg), .cmp_qe(cmp_qe), .cmp_ql(cmp_ql)
    );

    always #5 clk = ~clk;

    // 74HC85 function table; fault_now forces an all-low output.
    always_comb begin
        {cmp_qg, cmp_qe, cmp_ql} = 3'b000;
        if (fault_now)              {cmp_qg, cmp_qe, cmp_ql} = 3'b000;
        else if (cmp_a > cmp_b)     {cmp_qg, cmp_qe, cmp_ql} = 3'b100;
        else if (cmp_a < cmp_b)     {cmp_qg, cmp_qe, cmp_ql} = 3'b001;
        else if (cmp_ie)            {cmp_qg, cmp_qe, cmp_ql} = 3'b010;
        else if (cmp_ig && cmp_il)  {cmp_qg, cmp_qe, cmp_ql} = 3'b000;
        else if (!cmp_ig && !cmp_il){cmp_qg, cmp_qe, cmp_ql} = 3'b101;
        else                        {cmp_qg, cmp_qe, cmp_ql} = {cmp_ig, 1'b0, cmp_il};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one compare. ign: pulse start with other operands mid-run. inj: fault on nibble 2.
    // Returns the number of negedges from the first RUN cycle to done, busy count and cmp_a trace.
    task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tbv, input bit ign,
                           input bit inj, output int lat, output int bcnt,
                           output logic [15:0] trace, output logic ie0);
        int cyc;
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bcnt = 0; trace = '0; ie0 = 1'b0;
        while (!done && cyc < 20) begin
            fault_now = inj && (cyc == 2);
            if (cyc == 0) ie0 = cmp_ie;
            if (cyc < 4) trace[4*cyc +: 4] = cmp_a;
            if (busy) bcnt++;
            if (ign && cyc == 1) begin
                a = ~ta; b = ~tbv; start = 1'b1;
            end else begin
                start = 1'b0;
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        fault_now = 1'b0;
        start = 1'b0;
        lat = cyc;
    endtask

    task automatic check_result(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                                input int lat, input int bcnt);
        logic [2:0] expv;
        expv = (ta > tbv) ? 3'b100 : (ta < tbv) ? 3'b001 : 3'b010;
        chk({tag, "_lat"}, lat, N);
        chk({tag, "_busy"}, bcnt, N);
        chk({tag, "_gel"}, {gt, eq, lt}, expv);
        chk({tag, "_err"}, err, 0);
        $display("cmp %s a=%h b=%h gel=%b err=%b lat=%0d", tag, ta, tbv, {gt, eq, lt}, err, lat);
    endtask

    initial begin
        int lat, bcnt, cyc;
        logic [15:0] trace, ra, rb, xa, xb;
        logic ie0;
        bit saw;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; fault_now = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gel", {gt, eq, lt}, 3'b000);
        chk("rst_err", err, 0);
        chk("rst_casc", {cmp_ig, cmp_ie, cmp_il}, 3'b010);
        chk("rst_cmp_a", cmp_a, 0);
        rst = 1'b0;

        run_cmp(16'h1234, 16'h1234, 0, 0, lat, bcnt, trace, ie0);
        check_result("eq", 16'h1234, 16'h1234, lat, bcnt);
        chk("eq_done_1cyc", done, 1);
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("hold_eq", {gt, eq, lt}, 3'b010);

        run_cmp(16'h8000, 16'h7FFF, 0, 0, lat, bcnt, trace, ie0);
        check_result("msb_gt", 16'h8000, 16'h7FFF, lat, bcnt);
        run_cmp(16'h0FFF, 16'h1000, 0, 0, lat, bcnt, trace, ie0);
        check_result("msb_lt", 16'h0FFF, 16'h1000, lat, bcnt);
        run_cmp(16'hFFFE, 16'hFFFF, 0, 0, lat, bcnt, trace, ie0);
        check_result("lsb_lt", 16'hFFFE, 16'hFFFF, lat, bcnt);

        run_cmp(16'hABCD, 16'h0000, 0, 0, lat, bcnt, trace, ie0);
        check_result("seq", 16'hABCD, 16'h0000, lat, bcnt);
        chk("cmp_a_seq", trace, 16'hABCD);
        chk("first_ie", ie0, 1);

        // Start while busy: result must still reflect the first operands.
        run_cmp(16'h0003, 16'h0005, 1, 0, lat, bcnt, trace, ie0);
        check_result("ign", 16'h0003, 16'h0005, lat, bcnt);
        saw = 0;
        repeat (6) begin @(negedge clk); if (done || busy) saw = 1; end
        chk("ign_not_queued", saw, 0);

        // Back-to-back: start on the done cycle.
        run_cmp(16'h4444, 16'h4443, 0, 0, lat, bcnt, trace, ie0);
        check_result("b2b1", 16'h4444, 16'h4443, lat, bcnt);
        a = 16'h0100; b = 16'h0200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin @(negedge clk); cyc++; end
        chk("b2b_lat", cyc, N + 1);
        chk("b2b_gel", {gt, eq, lt}, 3'b001);
        $display("cmp b2b2 a=0100 b=0200 gel=%b cycles=%0d", {gt, eq, lt}, cyc);

        run_cmp(16'h5555, 16'h5555, 0, 1, lat, bcnt, trace, ie0);
        chk("fault_lat", lat, N);
        chk("fault_err", err, 1);
        $display("cmp fault a=5555 b=5555 err=%b", err);
        run_cmp(16'h5555, 16'h5555, 0, 0, lat, bcnt, trace, ie0);
        check_result("clean", 16'h5555, 16'h5555, lat, bcnt);

        // Reset while on nibble 2.
        @(negedge clk);
        a = 16'h9000; b = 16'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_cmp_a", cmp_a, 0);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gel", {gt, eq, lt, done}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (8) begin @(negedge clk); if (done) saw = 1; end
        chk("no_done_after_rst", saw, 0);
        $display("cmp rst_abort done_seen=%0d", saw);
        run_cmp(16'h9000, 16'h1000, 0, 0, lat, bcnt, trace, ie0);
        check_result("post_rst", 16'h9000, 16'h1000, lat, bcnt);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case (i % 4)
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(15, 0));
                default: rb = 16'($urandom);
            endcase
            xa = ra; xb = rb;
            run_cmp(xa, xb, 0, 0, lat, bcnt, trace, ie0);
            check_result("rand", xa, xb, lat, bcnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lzx_cmp_seq.md
Name: lzx_cmp_seq

Overview:
Sequencer that compares two wide unsigned words using a single external lzx_74HC85 4-bit magnitude comparator slice, time-multiplexed nibble by nibble. It processes the LSB nibble first and feeds each registered slice result back into the slice's cascade inputs, so the MSB-nibble step yields the full-width result. It sits between a requesting datapath (start/done handshake) and one shared lzx_74HC85 instance.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 1..16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  4*NIBBLES  operand A, unsigned; sampled with start
b  input  4*NIBBLES  operand B, unsigned; sampled with start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse; result valid
gt  output  1  registered result A>B
eq  output  1  registered result A==B
lt  output  1  registered result A<B
err  output  1  registered with done; a slice returned a non-one-hot result
cmp_a  output  4  to comparator A3..A0
cmp_b  output  4  to comparator B3..B0
cmp_ig  output  1  to comparator IA_g
cmp_ie  output  1  to comparator IA_e
cmp_il  output  1  to comparator IA_l
cmp_qg  input  1  from comparator QA_g (combinational)
cmp_qe  input  1  from comparator QA_e
cmp_ql  input  1  from comparator QA_l

Behaviour:
- States: IDLE, RUN. Registers: a_r, b_r, idx (ceil(log2(NIBBLES)) bits, min 1), cascade triple {cg,ce,cl}, err_acc.
- Reset (async, immediate): state=IDLE, idx=0, {cg,ce,cl}=010, err_acc=0, busy=0, done=0, gt=eq=lt=0, err=0.
- IDLE: busy=0; cmp_a=cmp_b=0; {cmp_ig,cmp_ie,cmp_il}=010. On an edge with start=1: a_r<=a, b_r<=b, idx<=0, {cg,ce,cl}<=010, err_acc<=0, state<=RUN, busy<=1.
- RUN: cmp_a=a_r[4*idx+3:4*idx], cmp_b=b_r[same]; cascade outputs driven from {cg,ce,cl}. Each edge: {cg,ce,cl}<={cmp_qg,cmp_qe,cmp_ql}; err_acc accumulates (|=) when the sampled triple is not exactly one-hot; idx<=idx+1.
- Final step (idx==NIBBLES-1): on that edge gt/eq/lt<=sampled cmp_q triple, err<=err_acc OR the current step's one-hot violation, done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge E0 -> done=1 in the cycle after edge E0+NIBBLES; exactly NIBBLES RUN cycles.
- done is high for exactly one cycle. gt/eq/lt/err hold their values until the next final step or reset.
- start while busy: ignored, not queued. start in the cycle done is high: accepted (state is IDLE); back-to-back throughput is one compare per NIBBLES+1 cycles.
- Operands changing during RUN have no effect (latched copies used).
- NIBBLES=1: one RUN cycle; the cascade inputs seen by the slice are 010.
- Reset mid-RUN: abort, return to reset values; no done pulse is generated.

Test Plan:
- NIBBLES=4, bench instantiates lzx_74HC85 on cmp_* ports. A=0x1234, B=0x1234, start pulse -> done in the cycle after edge E0+4; eq=1, gt=lt=0, err=0; busy high for exactly 4 cycles.
- A=0x8000, B=0x7FFF -> gt=1 (MSB nibble decides despite lower nibbles giving lt). A=0x0FFF, B=0x1000 -> lt=1. A=0xFFFE, B=0xFFFF -> lt=1 (LSB nibble propagates through three equal nibbles).
- Check cmp_a sequence for A=0xABCD: D, C, B, A on consecutive RUN cycles. Check cmp_ie=1 on the first RUN cycle.
- Apply start while busy with a new A/B -> ignored, first result reported unchanged. Apply start on the done cycle -> second result after a further 5 cycles.
- Replace the comparator model with one forcing 000 on nibble 2 -> err=1 with done. A subsequent clean compare -> err=0.
- Assert rst during RUN idx=2 -> busy, done, gt, eq, lt all 0 immediately; no done pulse follows; next start operates normally.
